// File: rtl/sev_seg_scan.sv
// Scanned driver for common-anode seven-segment digits sharing one segment bus, with a dark guard between slots.
// Define SEV_SEG_BRIGHTNESS_EN to add a 4-bit brightness input that trims the lit part of each SHOW phase.
module sev_seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 100000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
`ifdef SEV_SEG_BRIGHTNESS_EN
  input  logic [3:0]              brightness,
`endif
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [2:0]              digit_idx,
  output logic                    frame_tick
);

  localparam int CW       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int SHOW_LEN = SLOT_CYCLES - GUARD_CYCLES;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_LEN - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(NUM_DIGITS - 1);
  localparam logic [0:0]    ST_SHOW   = 1'b0;
  localparam logic [0:0]    ST_GUARD  = 1'b1;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [0:0]              state_q, state_d;
  logic [2:0]              idx_q, idx_d;
  logic [2:0]              nxt_q, nxt_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q, tick_d;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   dp_q, blank_q;

  // Shadow data padded to eight entries so the 3-bit digit index always addresses a full array.
  logic [3:0] nib8 [8];
  logic [7:0] dp8, blank8, zero_from;
  logic       dark_sel;
  logic [7:0] glyph;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pad
      if (gi < NUM_DIGITS) begin : g_real
        assign nib8[gi]   = value_q[4*gi +: 4];
        assign dp8[gi]    = dp_q[gi];
        assign blank8[gi] = blank_q[gi];
      end else begin : g_fill
        assign nib8[gi]   = 4'h0;
        assign dp8[gi]    = 1'b0;
        assign blank8[gi] = 1'b1;
      end
    end
  endgenerate

  always_comb begin : zero_scan
    logic acc;
    acc = 1'b1;
    zero_from = '0;
    for (int i = 7; i >= 0; i--) begin
      acc = acc & (nib8[i] == 4'h0);
      zero_from[i] = acc;
    end
  end

  function automatic logic [7:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 8'h81;  4'h1: hex_glyph = 8'hF3;
      4'h2: hex_glyph = 8'h49;  4'h3: hex_glyph = 8'h61;
      4'h4: hex_glyph = 8'h33;  4'h5: hex_glyph = 8'h25;
      4'h6: hex_glyph = 8'h05;  4'h7: hex_glyph = 8'hF1;
      4'h8: hex_glyph = 8'h01;  4'h9: hex_glyph = 8'h21;
      4'hA: hex_glyph = 8'h11;  4'hB: hex_glyph = 8'h07;
      4'hC: hex_glyph = 8'h8D;  4'hD: hex_glyph = 8'h43;
      4'hE: hex_glyph = 8'h0D;  default: hex_glyph = 8'h1D;
    endcase
  endfunction

  assign glyph    = hex_glyph(nib8[nxt_q]);
  assign dark_sel = blank8[nxt_q] | (lz_en & zero_from[nxt_q] & (nxt_q != 3'd0));

`ifdef SEV_SEG_BRIGHTNESS_EN
  logic [3:0]  bright_q;
  logic [31:0] lit_lhs, lit_rhs;
  logic        dim_off;
  assign lit_lhs = 32'(cnt_d) << 4;
  assign lit_rhs = (32'(bright_q) + 32'd1) * 32'(SHOW_LEN);
  assign dim_off = (lit_lhs >= lit_rhs);

  always_ff @(posedge clk) begin
    if (reset)                 bright_q <= 4'hF;
    else if (cnt_q == CNT_LAST) bright_q <= brightness;
  end
`endif

  always_comb begin
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    state_d = state_q;
    idx_d   = idx_q;
    nxt_d   = nxt_q;
    seg_d   = seg_q;
    an_d    = an_q;
    tick_d  = 1'b0;
    if (cnt_q == CNT_LAST) begin
      state_d = ST_SHOW;
      idx_d   = nxt_q;
      nxt_d   = (nxt_q == IDX_LAST) ? 3'd0 : nxt_q + 3'd1;
      tick_d  = (nxt_q == 3'd0);
      seg_d   = dark_sel ? 8'hFF : {glyph[7:1], ~dp8[nxt_q]};
      for (int i = 0; i < NUM_DIGITS; i++) an_d[i] = (nxt_q != 3'(i));
    end else if (GUARD_CYCLES > 0 && state_q == ST_SHOW && cnt_q == SHOW_LAST) begin
      state_d = ST_GUARD;
      seg_d   = 8'hFF;
      an_d    = '1;
    end
`ifdef SEV_SEG_BRIGHTNESS_EN
    else if (state_q == ST_SHOW && dim_off) begin
      seg_d = 8'hFF;
      an_d  = '1;
    end
`endif
  end

  // Reset parks the counter at terminal so the first free edge is the digit-0 SHOW entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= CNT_LAST;
      state_q <= ST_GUARD;
      idx_q   <= 3'd0;
      nxt_q   <= 3'd0;
      seg_q   <= 8'hFF;
      an_q    <= '1;
      tick_q  <= 1'b0;
      value_q <= '0;
      dp_q    <= '0;
      blank_q <= '1;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      nxt_q   <= nxt_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
      if (load) begin
        value_q <= value_in;
        dp_q    <= dp_in;
        blank_q <= blank_in;
      end
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sev_seg_scan.sv
// Directed bench for sev_seg_scan with 4 digits, 8-cycle slots and a 2-cycle guard.
module tb_sev_seg_scan;

  logic        clk = 1'b0;
  logic        reset, load, lz_en;
  logic [15:0] value_in;
  logic [3:0]  dp_in, blank_in;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic [2:0]  digit_idx;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sev_seg_scan #(.NUM_DIGITS(4), .SLOT_CYCLES(8), .GUARD_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .load(load), .value_in(value_in),
    .dp_in(dp_in), .blank_in(blank_in), .lz_en(lz_en),
`ifdef SEV_SEG_BRIGHTNESS_EN
    .brightness(4'hF),
`endif
    .seg(seg), .an(an), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic            lz;
    logic [3:0][7:0] exp_seg;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at the negedge just after a SHOW entry; returns at the negedge after the next entry.
  task automatic check_slot(input int d, input logic [7:0] exp_seg);
    logic [3:0] ea;
    ea = 4'hF;
    ea[d] = 1'b0;
    chk("idx", 32'(digit_idx), 32'(d));
    chk("an_entry", 32'(an), 32'(ea));
    chk("seg_entry", 32'(seg), 32'(exp_seg));
    chk("tick_entry", 32'(frame_tick), (d == 0) ? 32'd1 : 32'd0);
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      chk("an_show", 32'(an), 32'(ea));
      chk("seg_show", 32'(seg), 32'(exp_seg));
      chk("tick_show", 32'(frame_tick), 32'd0);
    end
    for (int k = 6; k < 8; k++) begin
      @(negedge clk);
      chk("an_guard", 32'(an), 32'hF);
      chk("seg_guard", 32'(seg), 32'hFF);
    end
    @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    value_in = v; dp_in = dp; blank_in = bl; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while (frame_tick !== 1'b1 && n < 48) begin
      @(negedge clk);
      n++;
    end
    chk("frame_wait", 32'(frame_tick), 32'd1);
  endtask

  initial begin
    vecs[0] = '{16'h12AF, 4'b0100, 4'b0000, 1'b0, {8'hF3, 8'h48, 8'h11, 8'h1D}};
    vecs[1] = '{16'h0050, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h25, 8'h81}};
    vecs[2] = '{16'h0050, 4'b0000, 4'b0000, 1'b0, {8'h81, 8'h81, 8'h25, 8'h81}};
    vecs[3] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'h81}};
    vecs[4] = '{16'h1234, 4'b1111, 4'b1010, 1'b0, {8'hFF, 8'h48, 8'hFF, 8'h32}};
    vecs[5] = '{16'h0D0C, 4'b1000, 4'b0000, 1'b1, {8'hFF, 8'h43, 8'h81, 8'h8D}};
    vecs[6] = '{16'h8976, 4'b0001, 4'b0000, 1'b1, {8'h01, 8'h21, 8'hF1, 8'h04}};

    reset = 1'b1; load = 1'b0; lz_en = 1'b0;
    value_in = 16'hFFFF; dp_in = 4'hF; blank_in = 4'h0;
    // load during reset must be ignored
    load = 1'b1;
    repeat (3) @(negedge clk);
    load = 1'b0;
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_idx", 32'(digit_idx), 32'd0);
    chk("rst_tick", 32'(frame_tick), 32'd0);

    reset = 1'b0;
    @(negedge clk);
    // idle after reset: shadow blank keeps every digit dark, two full frames
    for (int f = 0; f < 2; f++)
      for (int d = 0; d < 4; d++) check_slot(d, 8'hFF);

    for (int v = 0; v < 7; v++) begin
      lz_en = vecs[v].lz;
      do_load(vecs[v].value, vecs[v].dp, vecs[v].blank);
      @(negedge clk);
      wait_frame();
      for (int d = 0; d < 4; d++) check_slot(d, vecs[v].exp_seg[d]);
      $display("vector %0d value=%h lz=%0d checked", v, vecs[v].value, vecs[v].lz);
    end

    // load in the middle of digit 1 SHOW
    lz_en = 1'b0;
    do_load(16'h12AF, 4'b0000, 4'b0000);
    @(negedge clk);
    wait_frame();
    check_slot(0, 8'h1D);
    chk("mid_seg_d1", 32'(seg), 32'h11);
    @(negedge clk);
    @(negedge clk);
    do_load(16'h5555, 4'b0000, 4'b0000);
    for (int k = 3; k < 6; k++) begin
      chk("mid_hold_seg", 32'(seg), 32'h11);
      @(negedge clk);
    end
    chk("mid_guard_seg", 32'(seg), 32'hFF);
    @(negedge clk);
    chk("mid_guard_an", 32'(an), 32'hF);
    @(negedge clk);
    chk("mid_new_idx", 32'(digit_idx), 32'd2);
    chk("mid_new_seg", 32'(seg), 32'h25);
    $display("mid-slot load sequence checked");

    // reset during digit 2 GUARD
    repeat (6) @(negedge clk);
    chk("pre_rst_guard", 32'(an), 32'hF);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_seg", 32'(seg), 32'hFF);
    chk("mrst_an", 32'(an), 32'hF);
    chk("mrst_idx", 32'(digit_idx), 32'd0);
    chk("mrst_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rel_tick", 32'(frame_tick), 32'd1);
    chk("rel_idx", 32'(digit_idx), 32'd0);
    chk("rel_an", 32'(an), 32'hE);
    chk("rel_seg", 32'(seg), 32'hFF);
    $display("mid-slot reset sequence checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
